serial_adder_ctrl: RTL and testbench

//  Bit-serial adder. Sequences a single 1-bit full-adder cell (sum = a^b^c,

---
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: reuses one full-adder cell over WIDTH bits,
// LSB first, with a start/done handshake and a registered result.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_bit;
  logic             w_carry_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_sr_nxt;

  always_comb begin
    w_bit        = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    w_carry_nxt  = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
    w_accept     = start && ((r_state == IDLE) || (r_state == DONE));
    w_last       = (r_cnt == LAST);
    // New bit enters at the MSB; the concatenate-and-shift form also covers WIDTH=1.
    w_sum_sr_nxt = WIDTH'({w_bit, r_sum_sr} >> 1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_sr_nxt;
      r_carry  <= w_carry_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_sum_sr_nxt;
        r_cout <= w_carry_nxt;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: one WIDTH=8 and one WIDTH=1 instance,
// expectations from integer a+b+cin arithmetic and a cycle-accurate done schedule.
module tb_serial_adder_ctrl;

  typedef struct {
    int          d;
    logic [7:0]  s;
    logic        c;
    int unsigned dcyc;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_n, start, cin, busy, done, cout;
  logic [7:0]  a [2];
  logic [7:0]  b [2];
  logic [7:0]  sum0;
  logic [0:0]  sum1;
  logic [7:0]  last_s [2];
  logic        last_c [2];
  exp_t        sb[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin[0]),
    .busy(busy[0]), .done(done[0]), .sum(sum0), .cout(cout[0])
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .a(a[1][0:0]), .b(b[1][0:0]), .cin(cin[1]),
    .busy(busy[1]), .done(done[1]), .sum(sum1), .cout(cout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(int d);
    return (d == 0) ? 8 : 1;
  endfunction

  task automatic chk(string n, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
    end
  endtask

  task automatic mon(int d);
    logic [7:0] s;
    logic       exp_busy;
    int         idx;
    int         w;
    w = wid(d);
    s = (d == 0) ? sum0 : {7'b0, sum1};
    if (!rst_n[d]) begin
      last_s[d] = '0;
      last_c[d] = 1'b0;
      chk($sformatf("reset_outs%0d", d), {busy[d], done[d], cout[d], s}, 0);
      return;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].d == d && sb[i].dcyc < cyc) begin
        chk($sformatf("done_timeout%0d", d), 0, 1);
        sb.delete(i);
      end
    end
    exp_busy = 1'b0;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].d == d) begin
        if (cyc + w >= sb[i].dcyc && cyc < sb[i].dcyc) exp_busy = 1'b1;
        if (sb[i].dcyc == cyc) idx = i;
      end
    end
    chk($sformatf("busy%0d", d), busy[d], exp_busy);
    chk($sformatf("done%0d", d), done[d], (idx >= 0));
    if (idx >= 0) begin
      chk($sformatf("sum%0d", d), s, sb[idx].s);
      chk($sformatf("cout%0d", d), cout[d], sb[idx].c);
      last_s[d] = sb[idx].s;
      last_c[d] = sb[idx].c;
      sb.delete(idx);
    end else begin
      chk($sformatf("sum_held%0d", d), s, last_s[d]);
      chk($sformatf("cout_held%0d", d), cout[d], last_c[d]);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(int d, logic [7:0] av, logic [7:0] bv, logic cv);
    exp_t        e;
    int unsigned mask, t;
    int          w;
    w      = wid(d);
    mask   = (1 << w) - 1;
    t      = (av & mask) + (bv & mask) + cv;
    e.d    = d;
    e.s    = 8'(t & mask);
    e.c    = 1'((t >> w) & 1);
    e.dcyc = cyc + 1 + w;
    sb.push_back(e);
  endtask

  // Returns at the done cycle, so a following issue() lands back-to-back.
  task automatic issue(int d, logic [7:0] av, logic [7:0] bv, logic cv, bit hold);
    int w;
    w = wid(d);
    push_exp(d, av, bv, cv);
    a[d] = av; b[d] = bv; cin[d] = cv; start[d] = 1'b1;
    step();
    if (hold) begin
      a[d] = 8'h01; b[d] = 8'h01; cin[d] = 1'b0;
      repeat (w - 1) step();
      start[d] = 1'b0;
      step();
    end else begin
      start[d] = 1'b0;
      a[d] = 8'($urandom); b[d] = 8'($urandom); cin[d] = 1'($urandom);
      repeat (w) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    checks = 0; errors = 0;
    rst_n = '0; start = '0; cin = '0;
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    last_s[0] = '0; last_s[1] = '0; last_c[0] = 1'b0; last_c[1] = 1'b0;
    repeat (3) step();
    rst_n = '1;
    step();

    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    step();
    issue(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    step();
    issue(0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    step();
    issue(0, 8'h12, 8'h34, 1'b0, 1'b1);
    step();
    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    issue(0, 8'h10, 8'h20, 1'b0, 1'b0);
    step();

    // Abort an operation in its fourth RUN cycle.
    push_exp(0, 8'hC3, 8'h77, 1'b1);
    a[0] = 8'hC3; b[0] = 8'h77; cin[0] = 1'b1; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (3) step();
    rst_n[0] = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == 0) sb.delete(i);
    #1;
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_sum", sum0, 0);
    chk("abort_cout", cout[0], 0);
    step();
    rst_n[0] = 1'b1;
    step();
    issue(0, 8'h80, 8'h80, 1'b1, 1'b0);
    step();

    for (int c = 0; c < 8; c++) begin
      ra = 8'((c >> 2) & 1);
      rb = 8'((c >> 1) & 1);
      rc = 1'(c & 1);
      issue(1, ra, rb, rc, 1'b0);
      if (c[0]) step();
    end
    step();

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      issue(0, ra, rb, rc, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
    end
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      issue(1, ra, rb, rc, 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    repeat (4) step();
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
